// File: rtl/frame_delta_reconstructor.sv
// -----------------------------------------------------------------------------
// frame_delta_reconstructor
//
// Rebuilds new-frame pixels from a stream of signed differences (magnitude plus
// sign) and the co-located old-frame pixels. Sits between the difference
// decoder and the frame store. One difference beat is accepted per cycle on a
// valid/ready input. One reconstructed pixel per beat leaves on a registered
// valid/ready output. Pixels are counted per frame, the last pixel is marked,
// and completion is pulsed.
//
// Build option:
//   SATURATE_EN  defined  : out-of-range results clamp (overflow -> all ones,
//                           underflow -> 0)
//                undefined: out-of-range results wrap modulo 2^DATA_WIDTH
//   range_err behaves identically in both builds.
//
// Parameters:
//   DATA_WIDTH    pixel and difference magnitude width
//   FRAME_PIXELS  pixels per frame (>= 2)
//   CW            pixel counter width, $clog2(FRAME_PIXELS)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   begin a frame (sampled only in IDLE)
//   in_valid     in   difference beat present
//   in_ready     out  block can accept a beat this cycle
//   diff_mag     in   absolute difference
//   diff_sign    in   0: new = old + mag, 1: new = old - mag
//   old_pixel    in   co-located old-frame pixel
//   out_valid    out  reconstructed pixel present
//   out_ready    in   downstream accepts
//   out_pixel    out  reconstructed pixel
//   out_last     out  out_pixel is the last pixel of the frame
//   busy         out  state is not IDLE
//   frame_done   out  one-cycle pulse after the final output handshake
//   pixel_count  out  beats accepted in the current frame
//   range_err    out  sticky out-of-range flag, cleared by start or reset
// -----------------------------------------------------------------------------
module frame_delta_reconstructor #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_PIXELS = 64,
  parameter int CW           = $clog2(FRAME_PIXELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] diff_mag,
  input  logic                  diff_sign,
  input  logic [DATA_WIDTH-1:0] old_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CW-1:0]         pixel_count,
  output logic                  range_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_count;
  logic                  r_range_err;
  logic                  r_frame_done;
  logic [DATA_WIDTH-1:0] r_pixel_p1;
  logic                  r_last_p1;
  logic                  r_vld_p1;

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH:0]   w_ext;
  logic                  w_oor;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_out_hs;

`ifdef SATURATE_EN
  // Clamp toward the violated bound; in-range values pass through unchanged.
  function automatic logic [DATA_WIDTH-1:0] f_saturate(
    input logic [DATA_WIDTH-1:0] wrapped,
    input logic                  sign,
    input logic                  oor
  );
    if (!oor)
      return wrapped;
    return sign ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'b1}};
  endfunction
`endif

  // One extra bit catches both overflow (carry) and underflow (borrow):
  // for subtraction the top bit is set exactly when mag > old.
  assign w_sum  = {1'b0, old_pixel} + {1'b0, diff_mag};
  assign w_diff = {1'b0, old_pixel} - {1'b0, diff_mag};
  assign w_ext  = diff_sign ? w_diff : w_sum;
  assign w_oor  = w_ext[DATA_WIDTH];

`ifdef SATURATE_EN
  assign w_result = f_saturate(w_ext[DATA_WIDTH-1:0], diff_sign, w_oor);
`else
  assign w_result = w_ext[DATA_WIDTH-1:0];
`endif

  // A new beat may enter when the output register is empty or draining now.
  assign w_in_ready = (r_state == RUN) && (!r_vld_p1 || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_out_hs   = r_vld_p1 && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_accept && (r_count == LAST_IDX)) w_state_nxt = DRAIN;
      DRAIN:   if (w_out_hs && r_last_p1) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: output register and frame control ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_range_err  <= 1'b0;
      r_frame_done <= 1'b0;
      r_pixel_p1   <= '0;
      r_last_p1    <= 1'b0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= (r_state == DRAIN) && w_out_hs && r_last_p1;

      if ((r_state == IDLE) && start) begin
        r_count     <= '0;
        r_range_err <= 1'b0;
      end

      // A simultaneous handshake and acceptance simply replaces the register.
      if (w_accept) begin
        r_pixel_p1 <= w_result;
        r_last_p1  <= (r_count == LAST_IDX);
        r_vld_p1   <= 1'b1;
        r_count    <= r_count + CW'(1);
        if (w_oor)
          r_range_err <= 1'b1;
      end else if (w_out_hs) begin
        r_vld_p1  <= 1'b0;
        r_last_p1 <= 1'b0;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_vld_p1;
  assign out_pixel   = r_pixel_p1;
  assign out_last    = r_last_p1;
  assign busy        = (r_state != IDLE);
  assign frame_done  = r_frame_done;
  assign pixel_count = r_count;
  assign range_err   = r_range_err;

endmodule
